operand_stage: RTL

- Decode-side operand fetch and ID/EX pipeline register, directly downstream of the register file.
- Drives the register-file read addresses and consumes the combinational read data.
- Resolves RAW hazards by bypassing from the ALU, MEM and WB stages, and stalls on load-use.
- Registers operands and control into the EX stage under a valid/ready handshake.

---
 rtl/mips_pkg.sv | 19 +
 rtl/operand_stage_if.sv | 24 ++
 rtl/operand_bypass.sv | 41 ++++
 rtl/operand_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the decode-side operand stage.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_ALU
    } fwd_sel_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/operand_stage_if.sv
// Decoded-instruction channel from the ID stage into the operand stage.
interface operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic              id_ready;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_regwrite;
    logic              id_memread;
    logic [DATA_W-1:0] id_imm;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, id_imm,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, id_imm,
        output id_ready
    );
endinterface

// File: rtl/operand_bypass.sv
// Priority operand select for one source register: r0, then ALU > MEM > WB > regfile.
module operand_bypass
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              alu_en_i,
    input  logic [REG_AW-1:0] alu_dest_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              mem_en_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o,
    output fwd_sel_e          sel_o
);

    always_comb begin
        data_o = rf_data_i;
        sel_o  = FWD_RF;
        if (src_i == REG_AW'(REG_ZERO)) begin
            data_o = '0;
        end else if (alu_en_i && (alu_dest_i == src_i)) begin
            data_o = alu_data_i;
            sel_o  = FWD_ALU;
        end else if (mem_en_i && (mem_dest_i == src_i)) begin
            data_o = mem_data_i;
            sel_o  = FWD_MEM;
        end else if (wb_en_i && (wb_dest_i == src_i)) begin
            // regfile writes on the same edge, so its read data is still stale
            data_o = wb_data_i;
            sel_o  = FWD_WB;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch with bypassing, load-use stall and ID/EX register.
// Optional counters enabled by OPERAND_STAGE_PERF_EN.
module operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    operand_stage_if.slave    id_bus,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d;

    logic [DATA_W-1:0] opnd_a, opnd_b;
    fwd_sel_e          sel_a, sel_b;
    logic              alu_fwd_en;
    logic              load_use;
    logic              accept;

    assign rf_ra1 = id_bus.id_rs;
    assign rf_ra2 = id_bus.id_rt;

    // a load's ALU result is only an address, never the loaded data
    assign alu_fwd_en = ex_valid_q && ex_rw_q && !ex_mr_q;

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_a (
        .src_i      (id_bus.id_rs),
        .rf_data_i  (rf_rd1),
        .alu_en_i   (alu_fwd_en),
        .alu_dest_i (ex_dest_q),
        .alu_data_i (alu_result),
        .mem_en_i   (mem_regwrite),
        .mem_dest_i (mem_dest),
        .mem_data_i (mem_result),
        .wb_en_i    (wb_we),
        .wb_dest_i  (wb_dest),
        .wb_data_i  (wb_data),
        .data_o     (opnd_a),
        .sel_o      (sel_a)
    );

    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_b (
        .src_i      (id_bus.id_rt),
        .rf_data_i  (rf_rd2),
        .alu_en_i   (alu_fwd_en),
        .alu_dest_i (ex_dest_q),
        .alu_data_i (alu_result),
        .mem_en_i   (mem_regwrite),
        .mem_dest_i (mem_dest),
        .mem_data_i (mem_result),
        .wb_en_i    (wb_we),
        .wb_dest_i  (wb_dest),
        .wb_data_i  (wb_data),
        .data_o     (opnd_b),
        .sel_o      (sel_b)
    );

    assign load_use = ex_valid_q && ex_mr_q && ex_rw_q
                   && (ex_dest_q != REG_AW'(REG_ZERO)) && id_bus.id_valid
                   && ((ex_dest_q == id_bus.id_rs) || (ex_dest_q == id_bus.id_rt));

    assign id_bus.id_ready = !load_use && (!ex_valid_q || ex_ready) && !flush;
    assign accept          = id_bus.id_valid && id_bus.id_ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_dest_d  = ex_dest_q;
        ex_rw_d    = ex_rw_q;
        ex_mr_d    = ex_mr_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_a_d     = opnd_a;
            ex_b_d     = opnd_b;
            ex_imm_d   = id_bus.id_imm;
            ex_dest_d  = id_bus.id_dest;
            ex_rw_d    = id_bus.id_regwrite;
            ex_mr_d    = id_bus.id_memread;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_dest_q  <= '0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_dest_q  <= ex_dest_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_imm      = ex_imm_q;
    assign ex_dest     = ex_dest_q;
    assign ex_regwrite = ex_rw_q;
    assign ex_memread  = ex_mr_q;

`ifdef OPERAND_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic [1:0]  fwd_n;

    assign fwd_n = {1'b0, sel_a != FWD_RF} + {1'b0, sel_b != FWD_RF};

    // a flushed load-use cycle produces no bubble, so it is not counted
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (load_use && !flush) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (accept) begin
                fwd_cnt_q <= fwd_cnt_q + {30'd0, fwd_n};
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`else
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^{sel_a, sel_b};
    assign perf_stall_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif

endmodule
